// File: rtl/ebike_stim_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ebike_stim_pkg                                                  |
// | Purpose  : Shared types and constants for the e-bike stimulus sequencer:   |
// |            FSM state encoding, prime length, default geometry and the      |
// |            layout of one packed table vector.                              |
// | Ports    : none (package)                                                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package ebike_stim_pkg;

  // Default geometry shared by the sequencer, its interface and users.
  localparam int NUM_CH_DEF  = 4;
  localparam int CH_W_DEF    = 12;
  localparam int YAW_W_DEF   = 16;
  localparam int DEPTH_DEF   = 16;
  localparam int DWELL_W_DEF = 20;
  localparam int CAD_W_DEF   = 16;

  // Number of cycles spent in PRIME before the first vector is driven.
  localparam int PRIME_CYCLES = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Bit offsets of the fields inside one table word (default geometry).
  localparam int CH_LSB_DEF  = 0;
  localparam int YAW_LSB_DEF = NUM_CH_DEF * CH_W_DEF;
  localparam int CAD_LSB_DEF = YAW_LSB_DEF + YAW_W_DEF;
  localparam int VEC_W_DEF   = CAD_LSB_DEF + 2;

  // One table word: {cad_pick, yaw, ch[NUM_CH-1..0]}, channel 0 in the LSBs.
  typedef struct packed {
    logic [1:0]                       cad_pick;
    logic [YAW_W_DEF-1:0]             yaw;
    logic [NUM_CH_DEF*CH_W_DEF-1:0]   ch;
  } vec_t;

endpackage
`default_nettype wire

// File: rtl/ebike_stim_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ebike_stim_sequencer_if                                         |
// | Purpose  : Control/table-load bus and sensor outputs of the stimulus       |
// |            sequencer bundled into one interface.                           |
// | Ports    : master - drives wr_en/wr_addr/wr_data, num_vec, dwell,          |
// |                     cad_base, start, abort; observes the sensor outputs    |
// |            slave  - the sequencer side (mirror of master)                  |
// |            Outputs: ch_out, yaw_out, cadence, vec_idx, vec_strobe, busy,   |
// |                     done                                                   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface ebike_stim_sequencer_if
  import ebike_stim_pkg::*;
#(
  parameter int NUM_CH  = NUM_CH_DEF,
  parameter int CH_W    = CH_W_DEF,
  parameter int YAW_W   = YAW_W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int DWELL_W = DWELL_W_DEF,
  parameter int CAD_W   = CAD_W_DEF
);
  localparam int AW    = $clog2(DEPTH);
  localparam int VEC_W = NUM_CH * CH_W + YAW_W + 2;

  // Table load and run control
  logic                    wr_en;
  logic [AW-1:0]           wr_addr;
  logic [VEC_W-1:0]        wr_data;
  logic [AW:0]             num_vec;
  logic [DWELL_W-1:0]      dwell;
  logic [CAD_W-1:0]        cad_base;
  logic                    start;
  logic                    abort;

  // Sensor stimulus and status
  logic [NUM_CH*CH_W-1:0]  ch_out;
  logic [YAW_W-1:0]        yaw_out;
  logic                    cadence;
  logic [AW-1:0]           vec_idx;
  logic                    vec_strobe;
  logic                    busy;
  logic                    done;

  modport master (
    output wr_en, wr_addr, wr_data, num_vec, dwell, cad_base, start, abort,
    input  ch_out, yaw_out, cadence, vec_idx, vec_strobe, busy, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, num_vec, dwell, cad_base, start, abort,
    output ch_out, yaw_out, cadence, vec_idx, vec_strobe, busy, done
  );

endinterface
`default_nettype wire

// File: rtl/ebike_stim_sequencer_cadence.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ebike_cadence_gen                                               |
// | Purpose  : Cadence pulse train generator. Half-period is                   |
// |            cad_base << (cad_pick-1); cad_pick 00 holds the output low.     |
// | Ports    : clk        in  system clock                                     |
// |            RST_n      in  synchronous active-low reset                     |
// |            en_i       in  run enable (low forces output low)               |
// |            cad_pick_i in  speed pick of the current vector                 |
// |            cad_base_i in  half-period base (never 0 when enabled)          |
// |            cadence_o  out registered pulse train                           |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module ebike_cadence_gen
  import ebike_stim_pkg::*;
#(
  parameter int CAD_W = CAD_W_DEF
) (
  input  logic             clk,
  input  logic             RST_n,
  input  logic             en_i,
  input  logic [1:0]       cad_pick_i,
  input  logic [CAD_W-1:0] cad_base_i,
  output logic             cadence_o
);

  // Two extra bits so the largest shift (<<2) never overflows.
  localparam int HP_W = CAD_W + 2;

  logic [HP_W-1:0] half_per;
  logic [HP_W-1:0] cnt_q;
  logic [1:0]      pick_q;
  logic            cad_q;

  always_comb begin
    half_per = '0;
    case (cad_pick_i)
      2'b01:   half_per = {2'b00, cad_base_i};
      2'b10:   half_per = {1'b0, cad_base_i, 1'b0};
      2'b11:   half_per = {cad_base_i, 2'b00};
      default: half_per = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!RST_n) begin
      cnt_q  <= '0;
      pick_q <= 2'b00;
      cad_q  <= 1'b0;
    end else begin
      // Remembering 00 while disabled makes any later enable look like a
      // pick change, so every run starts from a clean low phase.
      pick_q <= en_i ? cad_pick_i : 2'b00;
      if (!en_i || (cad_pick_i == 2'b00) || (cad_pick_i != pick_q)) begin
        cnt_q <= '0;
        cad_q <= 1'b0;
      end else if (cnt_q == half_per - 1'b1) begin
        cnt_q <= '0;
        cad_q <= ~cad_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign cadence_o = cad_q;

endmodule
`default_nettype wire

// File: rtl/ebike_stim_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ebike_stim_sequencer                                            |
// | Purpose  : Plays a table of sensor vectors (analog channels, yaw rate,     |
// |            cadence pick) out in order, each held for a programmable        |
// |            dwell, and generates the matching cadence pulse train.          |
// | Ports    : clk    in  system clock                                         |
// |            RST_n  in  synchronous active-low reset                         |
// |            bus    slave modport of ebike_stim_sequencer_if:                |
// |                   wr_en/wr_addr/wr_data table load (IDLE/DONE only),       |
// |                   num_vec/dwell/cad_base sampled on start, start, abort,   |
// |                   ch_out, yaw_out, cadence, vec_idx, vec_strobe, busy,     |
// |                   done                                                     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module ebike_stim_sequencer
  import ebike_stim_pkg::*;
#(
  parameter int NUM_CH  = NUM_CH_DEF,
  parameter int CH_W    = CH_W_DEF,
  parameter int YAW_W   = YAW_W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int DWELL_W = DWELL_W_DEF,
  parameter int CAD_W   = CAD_W_DEF
) (
  input  logic                   clk,
  input  logic                   RST_n,
  ebike_stim_sequencer_if.slave  bus
);

  localparam int AW      = $clog2(DEPTH);
  localparam int CHS_W   = NUM_CH * CH_W;
  localparam int YAW_LSB = CHS_W;
  localparam int CAD_LSB = CHS_W + YAW_W;
  localparam int VEC_W   = CAD_LSB + 2;

  localparam logic [AW:0] DEPTH_L     = (AW + 1)'(DEPTH);
  localparam logic [1:0]  PRIME_LAST  = 2'(PRIME_CYCLES - 1);

  // Vector table; contents are undefined after reset.
  logic [VEC_W-1:0]   table_q [DEPTH];

  state_t             state_q;
  logic [1:0]         prime_cnt_q;
  logic [AW-1:0]      idx_q;
  logic [AW:0]        num_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [DWELL_W-1:0] dwell_cnt_q;
  logic [CAD_W-1:0]   cad_base_q;
  logic [CHS_W-1:0]   ch_q;
  logic [YAW_W-1:0]   yaw_q;
  logic [1:0]         cad_pick_q;
  logic               strobe_q;
  logic               done_q;
  logic               busy_q;

  logic               idle_like;
  logic               prime_end;
  logic               last_vec;
  logic               dwell_end;
  logic               apply_vec;
  logic               finish_run;
  logic               cad_en;
  logic [AW-1:0]      apply_addr;
  logic [VEC_W-1:0]   rd_vec;
  logic [AW:0]        num_eff;
  logic [DWELL_W-1:0] dwell_eff;
  logic [CAD_W-1:0]   cad_base_eff;

  assign idle_like = (state_q == IDLE) || (state_q == DONE);
  assign prime_end = (state_q == PRIME) && (prime_cnt_q == PRIME_LAST);
  assign last_vec  = ({1'b0, idx_q} == (num_q - 1'b1));
  assign dwell_end = (state_q == RUN) && (dwell_cnt_q == '0);

  // The first vector is driven on the edge that leaves PRIME; later vectors
  // replace the current one on the edge where its dwell has run out.
  assign apply_vec  = (prime_end && (num_q != '0)) || (dwell_end && !last_vec);
  assign finish_run = dwell_end && last_vec;
  assign apply_addr = (state_q == PRIME) ? '0 : idx_q + 1'b1;
  assign rd_vec     = table_q[apply_addr];

  // Run parameters captured on start; zero dwell/base behave as one.
  assign num_eff      = (bus.num_vec > DEPTH_L) ? DEPTH_L : bus.num_vec;
  assign dwell_eff    = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;
  assign cad_base_eff = (bus.cad_base == '0) ? CAD_W'(1) : bus.cad_base;

  // Table writes only land while no run is in progress.
  always_ff @(posedge clk) begin
    if (bus.wr_en && idle_like) begin
      table_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Sequencer FSM with registered outputs. Abort shares the reset path so
  // that it beats a simultaneous start and clears every output at once.
  always_ff @(posedge clk) begin
    if (!RST_n || bus.abort) begin
      state_q     <= IDLE;
      prime_cnt_q <= '0;
      idx_q       <= '0;
      num_q       <= '0;
      dwell_q     <= '0;
      dwell_cnt_q <= '0;
      cad_base_q  <= '0;
      ch_q        <= '0;
      yaw_q       <= '0;
      cad_pick_q  <= 2'b00;
      strobe_q    <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      done_q   <= 1'b0;

      if (apply_vec) begin
        idx_q       <= apply_addr;
        ch_q        <= rd_vec[CHS_W-1:0];
        yaw_q       <= rd_vec[YAW_LSB +: YAW_W];
        cad_pick_q  <= rd_vec[CAD_LSB +: 2];
        strobe_q    <= 1'b1;
        dwell_cnt_q <= dwell_q - 1'b1;
      end

      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            state_q     <= PRIME;
            busy_q      <= 1'b1;
            prime_cnt_q <= '0;
            num_q       <= num_eff;
            dwell_q     <= dwell_eff;
            cad_base_q  <= cad_base_eff;
            idx_q       <= '0;
            ch_q        <= '0;
            yaw_q       <= '0;
            cad_pick_q  <= 2'b00;
          end
        end

        PRIME: begin
          if (prime_end) begin
            if (num_q == '0) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= RUN;
            end
          end else begin
            prime_cnt_q <= prime_cnt_q + 1'b1;
          end
        end

        RUN: begin
          if (finish_run) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (!dwell_end) begin
            dwell_cnt_q <= dwell_cnt_q - 1'b1;
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Cadence stops on the same edge that ends or aborts the run, so it is
  // already low in the first DONE/IDLE cycle.
  assign cad_en = (state_q == RUN) && !finish_run && !bus.abort;

  ebike_cadence_gen #(
    .CAD_W (CAD_W)
  ) u_cadence (
    .clk        (clk),
    .RST_n      (RST_n),
    .en_i       (cad_en),
    .cad_pick_i (cad_pick_q),
    .cad_base_i (cad_base_q),
    .cadence_o  (bus.cadence)
  );

  assign bus.ch_out     = ch_q;
  assign bus.yaw_out    = yaw_q;
  assign bus.vec_idx    = idx_q;
  assign bus.vec_strobe = strobe_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_ebike_stim_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_ebike_stim_sequencer                                         |
// | Purpose  : Directed self-checking bench for ebike_stim_sequencer. Cycle    |
// |            index k counts clock edges after the edge that samples start;   |
// |            outputs are sampled 1ns after each edge.                        |
// | Ports    : none                                                           |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_ebike_stim_sequencer;
  import ebike_stim_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  always #5 clk = ~clk;

  ebike_stim_sequencer_if bus_if ();

  ebike_stim_sequencer dut (
    .clk   (clk),
    .RST_n (rst_n),
    .bus   (bus_if)
  );

  // Reference vectors: channel 0 (brake) sits in the low 12 bits.
  logic [47:0] exp_ch  [3] = '{48'h0A1_0B2_0C3_000, 48'h1A1_1B2_1C3_800, 48'h2A1_2B2_2C3_FFF};
  logic [15:0] exp_yaw [3] = '{16'h1111, 16'h2222, 16'h8001};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_vec(input logic [3:0] a, input logic [1:0] cp,
                           input logic [15:0] y, input logic [47:0] c);
    vec_t v;
    v.cad_pick = cp;
    v.yaw      = y;
    v.ch       = c;
    bus_if.wr_en   = 1'b1;
    bus_if.wr_addr = a;
    bus_if.wr_data = v;
    tick();
    bus_if.wr_en   = 1'b0;
  endtask

  task automatic load_std(input logic [1:0] pick1);
    for (int i = 0; i < 3; i++)
      write_vec(4'(i), (i == 1) ? pick1 : 2'b00, exp_yaw[i], exp_ch[i]);
  endtask

  // Returns 1ns after the edge that samples start (k = 0).
  task automatic start_run(input logic [4:0] n, input logic [19:0] d, input logic [15:0] cb);
    bus_if.num_vec  = n;
    bus_if.dwell    = d;
    bus_if.cad_base = cb;
    bus_if.start    = 1'b1;
    tick();
    bus_if.start    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    vec_cnt++; if (bus_if.ch_out !== 48'h0) begin err_cnt++; $display("FAIL reset_ch got %h want 0", bus_if.ch_out); end
    vec_cnt++; if (bus_if.yaw_out !== 16'h0) begin err_cnt++; $display("FAIL reset_yaw got %h want 0", bus_if.yaw_out); end
    vec_cnt++; if (bus_if.cadence !== 1'b0) begin err_cnt++; $display("FAIL reset_cadence got %b want 0", bus_if.cadence); end
    vec_cnt++; if (bus_if.vec_idx !== 4'h0) begin err_cnt++; $display("FAIL reset_idx got %h want 0", bus_if.vec_idx); end
    vec_cnt++; if (bus_if.vec_strobe !== 1'b0) begin err_cnt++; $display("FAIL reset_strobe got %b want 0", bus_if.vec_strobe); end
    vec_cnt++; if (bus_if.busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy got %b want 0", bus_if.busy); end
    vec_cnt++; if (bus_if.done !== 1'b0) begin err_cnt++; $display("FAIL reset_done got %b want 0", bus_if.done); end
    rst_n = 1'b1;
    tick();
    vec_cnt++; if (bus_if.busy !== 1'b0) begin err_cnt++; $display("FAIL reset_idle_busy got %b want 0", bus_if.busy); end
  endtask

  task automatic test_sequence();
    logic        e_strobe, e_done, e_busy;
    logic [47:0] e_ch;
    logic [15:0] e_yaw;
    logic [3:0]  e_idx;
    int          j;
    load_std(2'b00);
    start_run(5'd3, 20'd10, 16'd5);
    for (int k = 0; k <= 36; k++) begin
      if (k > 0) tick();
      e_strobe = (k == 3) || (k == 13) || (k == 23);
      e_done   = (k == 33);
      e_busy   = (k <= 32);
      j        = (k < 13) ? 0 : (k < 23) ? 1 : 2;
      e_idx    = 4'(j);
      e_ch     = (k < 3) ? 48'h0 : exp_ch[j];
      e_yaw    = (k < 3) ? 16'h0 : exp_yaw[j];
      vec_cnt++; if (bus_if.vec_strobe !== e_strobe) begin err_cnt++; $display("FAIL seq_strobe k=%0d got %b want %b", k, bus_if.vec_strobe, e_strobe); end
      vec_cnt++; if (bus_if.done !== e_done) begin err_cnt++; $display("FAIL seq_done k=%0d got %b want %b", k, bus_if.done, e_done); end
      vec_cnt++; if (bus_if.busy !== e_busy) begin err_cnt++; $display("FAIL seq_busy k=%0d got %b want %b", k, bus_if.busy, e_busy); end
      vec_cnt++; if (bus_if.ch_out !== e_ch) begin err_cnt++; $display("FAIL seq_ch k=%0d got %h want %h", k, bus_if.ch_out, e_ch); end
      vec_cnt++; if (bus_if.yaw_out !== e_yaw) begin err_cnt++; $display("FAIL seq_yaw k=%0d got %h want %h", k, bus_if.yaw_out, e_yaw); end
      vec_cnt++; if (bus_if.vec_idx !== e_idx) begin err_cnt++; $display("FAIL seq_idx k=%0d got %h want %h", k, bus_if.vec_idx, e_idx); end
      vec_cnt++; if (bus_if.cadence !== 1'b0) begin err_cnt++; $display("FAIL seq_cadence k=%0d got %b want 0", k, bus_if.cadence); end
    end
  endtask

  task automatic test_empty_run();
    start_run(5'd0, 20'd10, 16'd5);
    for (int k = 0; k <= 5; k++) begin
      if (k > 0) tick();
      vec_cnt++; if (bus_if.busy !== (k <= 2)) begin err_cnt++; $display("FAIL empty_busy k=%0d got %b want %b", k, bus_if.busy, (k <= 2)); end
      vec_cnt++; if (bus_if.done !== (k == 3)) begin err_cnt++; $display("FAIL empty_done k=%0d got %b want %b", k, bus_if.done, (k == 3)); end
      vec_cnt++; if (bus_if.ch_out !== 48'h0) begin err_cnt++; $display("FAIL empty_ch k=%0d got %h want 0", k, bus_if.ch_out); end
      vec_cnt++; if (bus_if.vec_strobe !== 1'b0) begin err_cnt++; $display("FAIL empty_strobe k=%0d got %b want 0", k, bus_if.vec_strobe); end
    end
  endtask

  task automatic test_cadence();
    int   tg[$];
    logic prev;
    write_vec(4'd0, 2'b10, 16'h0100, 48'h111_222_333_444);
    write_vec(4'd1, 2'b00, 16'h0200, 48'h555_666_777_888);
    start_run(5'd2, 20'd60, 16'd5);
    prev = 1'b0;
    for (int k = 0; k <= 126; k++) begin
      if (k > 0) tick();
      if (k <= 3) begin
        vec_cnt++; if (bus_if.cadence !== 1'b0) begin err_cnt++; $display("FAIL cad_prime k=%0d got %b want 0", k, bus_if.cadence); end
      end else if (k <= 64) begin
        if (bus_if.cadence !== prev) tg.push_back(k);
      end else begin
        vec_cnt++; if (bus_if.cadence !== 1'b0) begin err_cnt++; $display("FAIL cad_pick00 k=%0d got %b want 0", k, bus_if.cadence); end
      end
      if (k == 123) begin
        vec_cnt++; if (bus_if.done !== 1'b1) begin err_cnt++; $display("FAIL cad_done k=%0d got %b want 1", k, bus_if.done); end
      end
      prev = bus_if.cadence;
    end
    // Half-period 5<<1 = 10 over a 60-cycle vector gives at least 4 edges.
    vec_cnt++; if (tg.size() < 4) begin err_cnt++; $display("FAIL cad_toggles got %0d want >=4", tg.size()); end
    if (tg.size() >= 4) begin
      for (int i = 1; i < 4; i++) begin
        vec_cnt++; if (tg[i] - tg[i-1] != 10) begin err_cnt++; $display("FAIL cad_period i=%0d got %0d want 10", i, tg[i] - tg[i-1]); end
      end
    end
  endtask

  task automatic test_abort();
    load_std(2'b01);
    start_run(5'd3, 20'd10, 16'd2);
    for (int k = 1; k <= 16; k++) tick();
    bus_if.abort = 1'b1;
    bus_if.start = 1'b1;
    tick();
    bus_if.abort = 1'b0;
    bus_if.start = 1'b0;
    vec_cnt++; if (bus_if.busy !== 1'b0) begin err_cnt++; $display("FAIL abort_busy got %b want 0", bus_if.busy); end
    vec_cnt++; if (bus_if.ch_out !== 48'h0) begin err_cnt++; $display("FAIL abort_ch got %h want 0", bus_if.ch_out); end
    vec_cnt++; if (bus_if.yaw_out !== 16'h0) begin err_cnt++; $display("FAIL abort_yaw got %h want 0", bus_if.yaw_out); end
    vec_cnt++; if (bus_if.vec_idx !== 4'h0) begin err_cnt++; $display("FAIL abort_idx got %h want 0", bus_if.vec_idx); end
    vec_cnt++; if (bus_if.cadence !== 1'b0) begin err_cnt++; $display("FAIL abort_cadence got %b want 0", bus_if.cadence); end
    vec_cnt++; if (bus_if.vec_strobe !== 1'b0) begin err_cnt++; $display("FAIL abort_strobe got %b want 0", bus_if.vec_strobe); end
    for (int k = 0; k < 40; k++) begin
      tick();
      vec_cnt++; if (bus_if.done !== 1'b0) begin err_cnt++; $display("FAIL abort_nodone k=%0d got %b want 0", k, bus_if.done); end
      vec_cnt++; if (bus_if.busy !== 1'b0) begin err_cnt++; $display("FAIL abort_norestart k=%0d got %b want 0", k, bus_if.busy); end
    end
  endtask

  task automatic test_write_while_busy();
    start_run(5'd1, 20'd20, 16'd5);
    for (int k = 1; k <= 5; k++) tick();
    write_vec(4'd0, 2'b11, 16'hDEAD, 48'hABC_ABC_ABC_ABC);
    for (int k = 7; k <= 25; k++) tick();
    vec_cnt++; if (bus_if.busy !== 1'b0) begin err_cnt++; $display("FAIL wbusy_end got %b want 0", bus_if.busy); end
    start_run(5'd1, 20'd20, 16'd5);
    for (int k = 1; k <= 3; k++) tick();
    vec_cnt++; if (bus_if.ch_out !== exp_ch[0]) begin err_cnt++; $display("FAIL wbusy_ch got %h want %h", bus_if.ch_out, exp_ch[0]); end
    vec_cnt++; if (bus_if.yaw_out !== exp_yaw[0]) begin err_cnt++; $display("FAIL wbusy_yaw got %h want %h", bus_if.yaw_out, exp_yaw[0]); end
    vec_cnt++; if (bus_if.vec_strobe !== 1'b1) begin err_cnt++; $display("FAIL wbusy_strobe got %b want 1", bus_if.vec_strobe); end
    for (int k = 4; k <= 25; k++) tick();
  endtask

  task automatic test_reset_mid_run();
    load_std(2'b00);
    start_run(5'd3, 20'd10, 16'd5);
    for (int k = 1; k <= 8; k++) tick();
    rst_n = 1'b0;
    tick();
    vec_cnt++; if (bus_if.ch_out !== 48'h0) begin err_cnt++; $display("FAIL rstrun_ch got %h want 0", bus_if.ch_out); end
    vec_cnt++; if (bus_if.yaw_out !== 16'h0) begin err_cnt++; $display("FAIL rstrun_yaw got %h want 0", bus_if.yaw_out); end
    vec_cnt++; if (bus_if.busy !== 1'b0) begin err_cnt++; $display("FAIL rstrun_busy got %b want 0", bus_if.busy); end
    vec_cnt++; if (bus_if.done !== 1'b0) begin err_cnt++; $display("FAIL rstrun_done got %b want 0", bus_if.done); end
    repeat (2) tick();
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      vec_cnt++; if (bus_if.busy !== 1'b0) begin err_cnt++; $display("FAIL rstrun_idle k=%0d got %b want 0", k, bus_if.busy); end
      vec_cnt++; if (bus_if.vec_strobe !== 1'b0) begin err_cnt++; $display("FAIL rstrun_strobe k=%0d got %b want 0", k, bus_if.vec_strobe); end
    end
  endtask

  initial begin
    rst_n           = 1'b0;
    bus_if.wr_en    = 1'b0;
    bus_if.wr_addr  = '0;
    bus_if.wr_data  = '0;
    bus_if.num_vec  = '0;
    bus_if.dwell    = '0;
    bus_if.cad_base = '0;
    bus_if.start    = 1'b0;
    bus_if.abort    = 1'b0;

    test_reset();
    test_sequence();
    test_empty_run();
    test_cadence();
    test_abort();
    test_write_while_busy();
    test_reset_mid_run();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire
